// File: rtl/lr35902_oam_dma.sv
// LR35902 OAM DMA: an FF46 write edge starts a 160-byte copy from page XX00-XX9F into OAM.
// Optional LR35902_OAM_DMA_ECHO_EN maps source pages E0-FF down onto C0-DF (echo RAM).
module lr35902_oam_dma #(
   parameter int CYCLES_PER_BYTE = 4,
   parameter int STARTUP_CYCLES  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_adr,
   input  logic        cpu_write,
   input  logic [7:0]  cpu_dout,
   output logic [7:0]  reg_dout,
   input  logic [7:0]  din,
   output logic        dma_active,
   output logic [15:0] dma_adr,
   output logic        dma_read,
   output logic [7:0]  oam_adr,
   output logic [7:0]  oam_din,
   output logic        oam_write
);

   localparam int SLOT_W  = $clog2(CYCLES_PER_BYTE);
   localparam int START_W = $clog2(STARTUP_CYCLES + 1);
   localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(CYCLES_PER_BYTE - 1);
   localparam logic [START_W-1:0] START_LAST = START_W'(STARTUP_CYCLES - 1);
   localparam logic [7:0]         LAST_IDX   = 8'd159;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_XFER  = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   function automatic logic [7:0] page_map(input logic [7:0] base);
`ifdef LR35902_OAM_DMA_ECHO_EN
      if (base >= 8'hE0) begin
         page_map = base - 8'h20;
      end else begin
         page_map = base;
      end
`else
      page_map = base;
`endif
   endfunction

   state_t               state_r;
   logic                 prev_write_r;
   logic [7:0]           base_r;
   logic [7:0]           idx_r;
   logic [SLOT_W-1:0]    slot_cnt_r;
   logic [START_W-1:0]   start_cnt_r;
   logic                 start_s;
   logic [7:0]           src_page_s;

   assign start_s    = cpu_write && !prev_write_r && (cpu_adr == 16'hFF46);
   assign src_page_s = page_map(base_r);

   // Transfer FSM; oam_din doubles as the byte buffer captured at each slot end.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         prev_write_r <= 1'b0;
         base_r       <= 8'h00;
         idx_r        <= 8'h00;
         slot_cnt_r   <= '0;
         start_cnt_r  <= '0;
         reg_dout     <= 8'hFF;
         dma_active   <= 1'b0;
         dma_read     <= 1'b0;
         dma_adr      <= 16'h0000;
         oam_write    <= 1'b0;
         oam_adr      <= 8'h00;
         oam_din      <= 8'h00;
      end else begin
         prev_write_r <= cpu_write;
         oam_write    <= 1'b0;
         if (start_s) begin
            // A new write edge always wins, discarding any buffered byte.
            base_r      <= cpu_dout;
            reg_dout    <= cpu_dout;
            state_r     <= ST_START;
            start_cnt_r <= '0;
            slot_cnt_r  <= '0;
            idx_r       <= 8'h00;
            dma_active  <= 1'b1;
            dma_read    <= 1'b0;
            dma_adr     <= 16'h0000;
            oam_adr     <= 8'h00;
            oam_din     <= 8'h00;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  dma_active <= 1'b0;
                  dma_read   <= 1'b0;
               end
               ST_START: begin
                  if (start_cnt_r == START_LAST) begin
                     state_r    <= ST_XFER;
                     dma_read   <= 1'b1;
                     dma_adr    <= {src_page_s, 8'h00};
                     slot_cnt_r <= '0;
                     idx_r      <= 8'h00;
                  end else begin
                     start_cnt_r <= start_cnt_r + START_W'(1);
                  end
               end
               ST_XFER: begin
                  if (slot_cnt_r == SLOT_LAST) begin
                     slot_cnt_r <= '0;
                     oam_write  <= 1'b1;
                     oam_adr    <= idx_r;
                     oam_din    <= din;
                     if (idx_r == LAST_IDX) begin
                        state_r  <= ST_FLUSH;
                        dma_read <= 1'b0;
                        dma_adr  <= 16'h0000;
                     end else begin
                        idx_r   <= idx_r + 8'd1;
                        dma_adr <= {src_page_s, idx_r + 8'd1};
                     end
                  end else begin
                     slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
                  end
               end
               ST_FLUSH: begin
                  if (slot_cnt_r == SLOT_LAST) begin
                     state_r    <= ST_IDLE;
                     dma_active <= 1'b0;
                     idx_r      <= 8'h00;
                     oam_adr    <= 8'h00;
                     oam_din    <= 8'h00;
                  end else begin
                     slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
                  end
               end
               default: begin
                  state_r    <= ST_IDLE;
                  dma_active <= 1'b0;
                  dma_read   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/lr35902_oam_dma.md
# lr35902_oam_dma

OAM DMA controller for the LR35902 system. It decodes CPU writes to register FF46 and takes over the external memory bus to copy 160 bytes from page `XX00–XX9F` into OAM at `FE00–FE9F`. It drives the source address and read strobe for the top-level bus mux. It writes OAM through the `lr35902_oam` write port, and tells the top level when the CPU must be locked out of the bus.

## Interface
Parameters:
- `CYCLES_PER_BYTE`, default 4: clocks per transfer slot; must be ≥2.
- `STARTUP_CYCLES`, default 4: clocks between the FF46 write and the first read slot; must be ≥1.

Ports:
- `clk` in 1: system (gb) clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; forces idle.
- `cpu_adr` in 16: CPU address bus.
- `cpu_write` in 1: CPU write strobe (level).
- `cpu_dout` in 8: CPU write data.
- `reg_dout` out 8: FF46 readback value; the top level muxes it when `cpu_adr == 16'hFF46`.
- `din` in 8: source data returned from the merged read bus.
- `dma_active` out 1: the controller owns the external bus. The top level selects `dma_adr`/`dma_read` and blocks CPU bus and OAM access, except HRAM `FF80–FFFE`.
- `dma_adr` out 16: source address.
- `dma_read` out 1: source read strobe.
- `oam_adr` out 8: OAM write index.
- `oam_din` out 8: OAM write data.
- `oam_write` out 1: OAM write strobe, one clock wide.

## Operation
- **Start detect:** a rising edge of `cpu_write` with `cpu_adr == 16'hFF46`, i.e. registered previous `cpu_write` = 0 and current = 1.
  - On that clock edge: latch `base = cpu_dout`, set `reg_dout = cpu_dout`, enter START.
- **States:** IDLE → START → XFER → FLUSH → IDLE.
- **IDLE:** all outputs except `reg_dout` are low or zero.
- **START:** lasts `STARTUP_CYCLES` clocks.
  - `dma_active = 1`, `dma_read = 0`.
  - Slot counter and byte index `idx` cleared.
- **XFER:** 160 slots, `idx` 0..159, each `CYCLES_PER_BYTE` clocks.
  - `dma_read = 1` and `dma_adr = {src_page, idx}` for the whole slot.
  - `din` is captured into an 8-bit buffer on the edge that ends the slot.
  - In the first clock of slot `idx` (for `idx ≥ 1`), `oam_write = 1`, `oam_adr = idx-1`, `oam_din = buffer`.
  - XFER goes to FLUSH after the slot with `idx = 159`.
- **FLUSH:** one slot of `CYCLES_PER_BYTE` clocks.
  - `dma_read = 0`, `dma_active = 1`.
  - In the first clock: `oam_write = 1`, `oam_adr = 159`, `oam_din = buffer`.
  - Goes to IDLE after the slot.
- **Restart:** a new FF46 write edge in any non-IDLE state re-enters START with the new base. The buffered byte is discarded and no pending OAM write is issued.
- **Ignored writes:** FF46 writes only latch on the `cpu_write` rising edge; holding `cpu_write` high does not retrigger. Writes to any other address are ignored.
- **Widths:** `idx` is 8 bits and never exceeds 159. `oam_adr` is `idx-1` for the write in slot `idx`, or 159 in FLUSH, so it never wraps. The slot counter is `$clog2(CYCLES_PER_BYTE)` bits.

## Timing
- **Reset values:** `dma_active = 0`, `dma_read = 0`, `dma_adr = 0`, `oam_write = 0`, `oam_adr = 0`, `oam_din = 0`, `reg_dout = 8'hFF`, state IDLE.
- **Reset mid-transfer:** everything returns to reset values immediately (asynchronous); OAM keeps whatever was already written.
- **Start latency:** `dma_active` rises the clock after the start edge is detected. The first `dma_read` comes `STARTUP_CYCLES` clocks later.
- **Duration:** `dma_active` is high for exactly `STARTUP_CYCLES + 161*CYCLES_PER_BYTE` clocks (648 with defaults).
- **OAM write lag:** the OAM write of byte n occurs `CYCLES_PER_BYTE` clocks after the start of read slot n, exactly one clock wide.
- **Outputs:** all outputs are registered.

## Configuration
- `LR35902_OAM_DMA_ECHO_EN` defined:
  - `src_page = base - 8'h20` when `base ≥ 8'hE0`, mirroring echo RAM onto `C0–DF`.
  - Otherwise `src_page = base`.
- Undefined: `src_page = base` always; pages `E0–FF` are read as-is.
- The macro never changes timing or `reg_dout`.

## Test plan
- **Reset:** reset asserted → all outputs at reset values, `reg_dout = 8'hFF`; release → no activity without an FF46 write.
- **Full copy, base 8'hC1:**
  - `din` models `mem[a] = a[7:0] ^ 8'h5A`.
  - Required: 160 `oam_write` pulses with `oam_adr` 0..159 and `oam_din = adr ^ 8'h5A`.
  - Required: `dma_adr` runs C100..C19F and `dma_active` stays high for 648 clocks.
- **Restart:** write 8'hC0, then write 8'hD0 during slot 50 → no OAM write for the pending byte; a fresh START follows; the next reads begin at D000 and OAM 0..159 ends with D0xx data.
- **Echo mapping, base 8'hE2:**
  - With `LR35902_OAM_DMA_ECHO_EN` → `dma_adr` starts at C200.
  - Without it → `dma_adr` starts at E200.
- **Write handling:**
  - `cpu_write` held high for 10 clocks at FF46 → exactly one transfer.
  - A write to FF47 → no transfer.
  - `reg_dout` reflects the last FF46 write.
- **Async reset during slot 80** → `dma_active` and `oam_write` drop before the next clock edge; a subsequent FF46 write performs a complete 160-byte transfer.
